// File: rtl/mmul_sequencer.sv
// Job-level sequencer for the NxN systolic matrix-multiply array: streams weights, activations
// and zero flush rows into the array, then forwards the requested result rows and drops flush results.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_WLOAD  | passing N weight rows to the array, load_weight high
// S_WGAP   | load_weight held high with no beats for LOAD_GAP cycles
// S_STREAM | passing cmd_rows activation rows to the array
// S_FLUSH  | driving FLUSH zero rows to drain the array
// S_DRAIN  | no input beats; waiting for rows+FLUSH results
// S_DONE   | one-cycle done pulse
module mmul_sequencer #(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int ROWS_W       = 16,
    parameter int FLUSH        = 2 * N,
    parameter int LOAD_GAP     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ROWS_W-1:0]            cmd_rows,
    input  logic                         cmd_reload,
    input  logic [N*DATA_WIDTH-1:0]      w_tdata,
    input  logic                         w_tvalid,
    output logic                         w_tready,
    input  logic [N*DATA_WIDTH-1:0]      a_tdata,
    input  logic                         a_tvalid,
    output logic                         a_tready,
    output logic [N*DATA_WIDTH-1:0]      arr_tdata,
    output logic                         arr_tvalid,
    input  logic                         arr_tready,
    output logic                         arr_load_weight,
    input  logic [N*RESULT_WIDTH-1:0]    res_tdata,
    input  logic                         res_tvalid,
    output logic                         res_tready,
    output logic [N*RESULT_WIDTH-1:0]    out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic                         out_tlast,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_WGAP, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ROWS_W-1:0] CNT_ONE   = ROWS_W'(1);
    localparam logic [ROWS_W-1:0] N_CNT     = ROWS_W'(N);
    localparam logic [ROWS_W-1:0] GAP_CNT   = ROWS_W'(LOAD_GAP);
    localparam logic [ROWS_W-1:0] FLUSH_CNT = ROWS_W'(FLUSH);
    localparam logic [ROWS_W:0]   RC_ONE    = (ROWS_W + 1)'(1);
    localparam logic [ROWS_W:0]   FLUSH_EXT = (ROWS_W + 1)'(FLUSH);

    state_t              state_q, state_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [ROWS_W-1:0]   cnt_q, cnt_d;
    logic [ROWS_W:0]     rc_q, rc_d;
    logic                res_active;
    logic                fwd;
    logic                res_hs;
    state_t              post_load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d         = state_q;
        rows_d          = rows_q;
        cnt_d           = cnt_q;
        rc_d            = rc_q;
        cmd_ready       = 1'b0;
        w_tready        = 1'b0;
        a_tready        = 1'b0;
        arr_tdata       = '0;
        arr_tvalid      = 1'b0;
        arr_load_weight = 1'b0;
        res_tready      = 1'b0;
        out_tdata       = '0;
        out_tvalid      = 1'b0;
        out_tlast       = 1'b0;
        done            = 1'b0;
        post_load       = (rows_q != '0) ? S_STREAM : S_DONE;

        // Result forwarding depends only on how many results have been seen, not on input progress.
        res_active = (state_q == S_STREAM) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
        fwd        = (rc_q < {1'b0, rows_q});
        if (res_active) begin
            if (fwd) begin
                out_tdata  = res_tdata;
                out_tvalid = res_tvalid;
                res_tready = out_tready;
                out_tlast  = (rc_q == ({1'b0, rows_q} - RC_ONE));
            end else begin
                res_tready = 1'b1;
            end
        end
        res_hs = res_tvalid && res_tready;
        if (res_hs) rc_d = rc_q + RC_ONE;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rows_d = cmd_rows;
                    rc_d   = '0;
                    cnt_d  = '0;
                    if (cmd_reload) begin
                        state_d = S_WLOAD;
                        cnt_d   = N_CNT;
                    end else if (cmd_rows != '0) begin
                        state_d = S_STREAM;
                        cnt_d   = cmd_rows;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WLOAD: begin
                arr_load_weight = 1'b1;
                arr_tdata       = w_tdata;
                arr_tvalid      = w_tvalid;
                w_tready        = arr_tready;
                if (w_tvalid && arr_tready) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (LOAD_GAP > 0) begin
                            state_d = S_WGAP;
                            cnt_d   = GAP_CNT;
                        end else begin
                            state_d = post_load;
                            cnt_d   = rows_q;
                        end
                    end
                end
            end
            S_WGAP: begin
                arr_load_weight = 1'b1;
                cnt_d           = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = post_load;
                    cnt_d   = rows_q;
                end
            end
            S_STREAM: begin
                arr_tdata  = a_tdata;
                arr_tvalid = a_tvalid;
                a_tready   = arr_tready;
                if (a_tvalid && arr_tready) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FLUSH;
                        cnt_d   = FLUSH_CNT;
                    end
                end
            end
            S_FLUSH: begin
                arr_tvalid = 1'b1;
                if (arr_tready) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rc_d >= ({1'b0, rows_q} + FLUSH_EXT)) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // No command may be taken while reset is held.
        cmd_ready = cmd_ready && reset;
    end

endmodule

// File: tb/tb_mmul_sequencer.sv
// Randomized self-checking bench for mmul_sequencer: per-job scoreboards of array beats and
// forwarded results, built from the job description, plus cycle-level timing expectations.
module tb_mmul_sequencer;

    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int RW       = 32;
    localparam int ROWS_W   = 16;
    localparam int FLUSH    = 2 * N;
    localparam int LOAD_GAP = 2;
    localparam int AW       = N * DW;
    localparam int RSW      = N * RW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 0, cmd_ready, cmd_reload = 0;
    logic [ROWS_W-1:0] cmd_rows = '0;
    logic [AW-1:0]     w_tdata = '0, a_tdata = '0, arr_tdata;
    logic              w_tvalid = 0, w_tready, a_tvalid = 0, a_tready;
    logic              arr_tvalid, arr_tready = 0, arr_load_weight;
    logic [RSW-1:0]    res_tdata = '0, out_tdata;
    logic              res_tvalid = 0, res_tready, out_tvalid, out_tready = 0, out_tlast;
    logic              busy, done;

    mmul_sequencer #(
        .N(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ROWS_W(ROWS_W),
        .FLUSH(FLUSH), .LOAD_GAP(LOAD_GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows), .cmd_reload(cmd_reload),
        .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .arr_tdata(arr_tdata), .arr_tvalid(arr_tvalid), .arr_tready(arr_tready),
        .arr_load_weight(arr_load_weight),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [RSW-1:0] got, input logic [RSW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0]  w_q[$];
    logic [AW-1:0]  a_q[$];
    logic [RSW-1:0] r_q[$];
    logic [AW:0]    arr_log[$];
    logic [RSW:0]   out_log[$];
    int  stall_pct = 0;
    int  cyc = 0;
    int  k_c, k_w, k_f, k_r, k_d, k_fall;
    int  done_cnt, wrdy_cnt, outv_cnt;
    bit  busy_after, a_seen, pulse_chk = 0;
    bit  w_hs, a_hs, r_hs;
    bit  prev_load, prev_stall;
    logic [AW-1:0] prev_data;

    task automatic monitor();
        cyc++;
        w_hs = w_tvalid && w_tready;
        a_hs = a_tvalid && a_tready;
        r_hs = res_tvalid && res_tready;
        if (cmd_valid && cmd_ready) k_c = cyc;
        if (cyc == k_c + 1) busy_after = busy;
        if (prev_stall) begin
            check("arr_hold_valid", RSW'(arr_tvalid), RSW'(1));
            check("arr_hold_data", RSW'(arr_tdata), RSW'(prev_data));
        end
        prev_stall = arr_tvalid && !arr_tready;
        prev_data  = arr_tdata;
        if (arr_tvalid && arr_tready) begin
            arr_log.push_back({arr_load_weight, arr_tdata});
            k_f = cyc;
            if (arr_load_weight) k_w = cyc;
        end
        if (prev_load && !arr_load_weight) k_fall = cyc;
        prev_load = arr_load_weight;
        if (r_hs) k_r = cyc;
        if (a_tready) a_seen = 1;
        if (out_tvalid) outv_cnt++;
        if (out_tvalid && out_tready) out_log.push_back({out_tlast, out_tdata});
        if (done) begin
            done_cnt++;
            k_d = cyc;
        end
        if (w_tready) wrdy_cnt++;
        if (pulse_chk) check("busy_cmd_ready", RSW'(cmd_ready), RSW'(0));
    endtask

    // Sources hold valid/data until a handshake; readies toggle freely.
    task automatic drive();
        if (w_hs) void'(w_q.pop_front());
        if (a_hs) void'(a_q.pop_front());
        if (r_hs) void'(r_q.pop_front());
        if (!w_tvalid || w_hs) begin
            w_tvalid = (w_q.size() > 0) && ($urandom_range(99) >= stall_pct);
            w_tdata  = (w_q.size() > 0) ? w_q[0] : '0;
        end
        if (!a_tvalid || a_hs) begin
            a_tvalid = (a_q.size() > 0) && ($urandom_range(99) >= stall_pct);
            a_tdata  = (a_q.size() > 0) ? a_q[0] : '0;
        end
        if (!res_tvalid || r_hs) begin
            res_tvalid = (r_q.size() > 0) && ($urandom_range(99) >= stall_pct);
            res_tdata  = (r_q.size() > 0) ? r_q[0] : '0;
        end
        arr_tready = ($urandom_range(99) >= stall_pct);
        out_tready = ($urandom_range(99) >= stall_pct);
        w_hs = 0; a_hs = 0; r_hs = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_job(input int rows, input bit reload, input bit pulse, input int stall, input bit abort);
        logic [AW:0]    exp_arr[$];
        logic [RSW-1:0] exp_res[$];
        logic [RSW-1:0] rv;
        logic [AW-1:0]  dv;
        bit pulsed = 0;
        int nr;
        stall_pct = stall;
        w_q.delete(); a_q.delete(); r_q.delete();
        arr_log.delete(); out_log.delete();
        exp_arr.delete(); exp_res.delete();
        if (reload) for (int i = 0; i < N; i++) begin
            dv = AW'($urandom);
            w_q.push_back(dv);
            exp_arr.push_back({1'b1, dv});
        end
        for (int i = 0; i < rows; i++) begin
            dv = AW'($urandom);
            a_q.push_back(dv);
            exp_arr.push_back({1'b0, dv});
        end
        if (rows > 0) for (int i = 0; i < FLUSH; i++) exp_arr.push_back('0);
        nr = (rows > 0) ? rows + FLUSH : 0;
        for (int i = 0; i < nr; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            r_q.push_back(rv);
            if (i < rows) exp_res.push_back(rv);
        end
        k_c = -100; k_w = -100; k_f = -100; k_r = -100; k_d = -100; k_fall = -100;
        done_cnt = 0; wrdy_cnt = 0; outv_cnt = 0;
        busy_after = 0; a_seen = 0; prev_stall = 0; prev_load = arr_load_weight;
        w_tvalid = 0; a_tvalid = 0; res_tvalid = 0;
        drive();
        cmd_valid = 1; cmd_rows = ROWS_W'(rows); cmd_reload = reload;
        for (int i = 0; i < 50 && k_c < 0; i++) tick();
        cmd_valid = 0;
        check("cmd_accepted", RSW'(k_c >= 0), RSW'(1));
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            if (abort && a_seen) return;
            if (pulse && !pulsed && arr_log.size() > exp_arr.size() - FLUSH) begin
                cmd_valid = 1; cmd_rows = 7; cmd_reload = 1;
                pulsed = 1; pulse_chk = 1;
            end
            tick();
            if (pulse_chk) begin
                cmd_valid = 0;
                pulse_chk = 0;
            end
        end
        if (abort) begin
            check("abort_reached_stream", RSW'(a_seen), RSW'(1));
            return;
        end
        check("done_seen", RSW'(done_cnt > 0), RSW'(1));
        repeat (3) tick();
        check("done_count", RSW'(done_cnt), RSW'(1));
        check("idle_after_job", RSW'(busy), RSW'(0));
        check("busy_after_cmd", RSW'(busy_after), RSW'(1));
        check("arr_beats", RSW'(arr_log.size()), RSW'(exp_arr.size()));
        for (int i = 0; i < arr_log.size() && i < exp_arr.size(); i++)
            check("arr_beat", RSW'(arr_log[i]), RSW'(exp_arr[i]));
        check("out_beats", RSW'(out_log.size()), RSW'(rows));
        for (int i = 0; i < out_log.size() && i < rows; i++) begin
            check("out_data", out_log[i][RSW-1:0], exp_res[i]);
            check("out_tlast", RSW'(out_log[i][RSW]), RSW'(i == rows - 1));
        end
        if (!reload) check("w_tready_quiet", RSW'(wrdy_cnt), RSW'(0));
        if (rows == 0) check("no_out_valid", RSW'(outv_cnt), RSW'(0));
        if (reload) check("load_fall_cycle", RSW'(k_fall), RSW'(k_w + LOAD_GAP + 1));
        if (rows > 0)
            check("done_cycle", RSW'(k_d), RSW'(((k_f + 1 > k_r) ? k_f + 1 : k_r) + 1));
        else if (reload)
            check("done_cycle", RSW'(k_d), RSW'(k_w + LOAD_GAP + 1));
        else
            check("done_cycle", RSW'(k_d), RSW'(k_c + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, RSW'({cmd_ready, busy, done, arr_tvalid, arr_load_weight, w_tready,
                         a_tready, res_tready, out_tvalid, out_tlast}), RSW'(0));
        check({tag, "_tdata"}, RSW'(arr_tdata), RSW'(0));
    endtask

    initial begin
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        reset = 1;
        @(posedge clk);
        #1;
        check("cmd_ready_after_reset", RSW'(cmd_ready), RSW'(1));

        run_job(4, 1, 0, 0, 0);
        run_job(3, 0, 0, 0, 0);
        run_job(0, 1, 0, 0, 0);
        run_job(0, 0, 0, 0, 0);
        run_job(5, 1, 1, 0, 0);
        run_job(6, 1, 0, 40, 0);

        run_job(6, 1, 0, 20, 1);
        reset = 0;
        @(posedge clk);
        #1;
        check_reset_outputs("midjob_reset");
        reset = 1;
        w_tvalid = 0; a_tvalid = 0; res_tvalid = 0;
        @(posedge clk);
        #1;
        check("cmd_ready_after_midjob", RSW'(cmd_ready), RSW'(1));
        run_job(4, 1, 0, 30, 0);

        for (int j = 0; j < 10; j++)
            run_job($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 50), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
